// File: rtl/uart_byte_transmitter.sv
// Serializes a masked 32-bit sample word (byte 0 first) or a single metadata byte as UART frames.
// Define UART_TX_PARITY_EN to append an even parity bit after the data bits (8E1 instead of 8N1).
module uart_byte_transmitter #(
   parameter int BAUD_DIV = 868
) (
   input  logic        clock,
   input  logic        extReset,
   input  logic [31:0] dataIn,
   input  logic [3:0]  disabledGroups,
   input  logic        write,
   input  logic        writeMeta,
   input  logic [7:0]  meta_data,
   output logic        tx,
   output logic        xmit_idle,
   output logic        busy
);

   localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam logic [3:0]        LAST_BIT  = 4'(FRAME_BITS - 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      SELECT,
      SEND
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [31:0]             word_q;
   logic [3:0]              mask_q;
   logic [2:0]              byte_idx;
   logic [FRAME_BITS-1:0]   shift_q;
   logic [3:0]              bit_cnt;
   logic [BAUD_W-1:0]       baud_cnt;

   logic                    found;
   logic [2:0]              sel_idx;
   logic [7:0]              sel_byte;
   logic                    baud_term;
   logic                    frame_done;
   logic [FRAME_BITS-1:0]   frame;

   // Lowest still-enabled byte at or above the current index; descending scan leaves the lowest hit.
   always_comb begin
      found   = 1'b0;
      sel_idx = 3'd0;
      for (int k = 3; k >= 0; k--) begin
         if ((3'(k) >= byte_idx) && !mask_q[k]) begin
            found   = 1'b1;
            sel_idx = 3'(k);
         end
      end
   end

   always_comb begin
      sel_byte = word_q[7:0];
      case (sel_idx[1:0])
         2'd0: sel_byte = word_q[7:0];
         2'd1: sel_byte = word_q[15:8];
         2'd2: sel_byte = word_q[23:16];
         2'd3: sel_byte = word_q[31:24];
         default: sel_byte = word_q[7:0];
      endcase
   end

`ifdef UART_TX_PARITY_EN
   assign frame = {1'b1, ^sel_byte, sel_byte, 1'b0};
`else
   assign frame = {1'b1, sel_byte, 1'b0};
`endif

   assign baud_term  = (baud_cnt == BAUD_LAST);
   assign frame_done = (state == SEND) && baud_term && (bit_cnt == LAST_BIT);

   always_ff @(posedge clock) begin
      if (extReset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      tx         = 1'b1;
      xmit_idle  = 1'b0;
      case (state)
         IDLE: begin
            xmit_idle = 1'b1;
            if (write || writeMeta) begin
               state_next = SELECT;
            end
         end
         SELECT: begin
            state_next = found ? SEND : IDLE;
         end
         SEND: begin
            tx = shift_q[0];
            if (frame_done) begin
               state_next = SELECT;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = !xmit_idle;

   // Job latches, byte cursor and the per-frame bit/baud counters.
   always_ff @(posedge clock) begin
      if (extReset) begin
         word_q   <= '0;
         mask_q   <= '0;
         byte_idx <= '0;
         shift_q  <= '0;
         bit_cnt  <= '0;
         baud_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (write) begin
                  word_q   <= dataIn;
                  mask_q   <= disabledGroups;
                  byte_idx <= 3'd0;
               end else if (writeMeta) begin
                  word_q   <= {24'd0, meta_data};
                  mask_q   <= 4'b1110;
                  byte_idx <= 3'd0;
               end
            end
            SELECT: begin
               if (found) begin
                  shift_q  <= frame;
                  bit_cnt  <= 4'd0;
                  baud_cnt <= '0;
                  byte_idx <= sel_idx + 3'd1;
               end
            end
            SEND: begin
               if (baud_term) begin
                  baud_cnt <= '0;
                  shift_q  <= {1'b1, shift_q[FRAME_BITS-1:1]};
                  bit_cnt  <= bit_cnt + 4'd1;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_byte_transmitter.sv
// Randomized self-checking bench: a queue-based model predicts tx/xmit_idle for every cycle of a job.
module tb_uart_byte_transmitter;

   localparam int BAUD = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   logic        clock = 1'b0;
   logic        extReset;
   logic [31:0] dataIn;
   logic [3:0]  disabledGroups;
   logic        write;
   logic        writeMeta;
   logic [7:0]  meta_data;
   logic        tx;
   logic        xmit_idle;
   logic        busy;

   int compare_count  = 0;
   int mismatch_count = 0;

   // Each entry is {tx, xmit_idle} expected for one cycle, starting with cycle 1 after the strobe.
   logic [1:0] exp_q[$];

   uart_byte_transmitter #(.BAUD_DIV(BAUD)) dut (
      .clock          (clock),
      .extReset       (extReset),
      .dataIn         (dataIn),
      .disabledGroups (disabledGroups),
      .write          (write),
      .writeMeta      (writeMeta),
      .meta_data      (meta_data),
      .tx             (tx),
      .xmit_idle      (xmit_idle),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      compare_count++;
      if (got !== want) begin
         mismatch_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic checkAll(input string tag, input logic want_tx, input logic want_idle);
      checkOutput($sformatf("%s.tx", tag), {31'd0, tx}, {31'd0, want_tx});
      checkOutput($sformatf("%s.xmit_idle", tag), {31'd0, xmit_idle}, {31'd0, want_idle});
      checkOutput($sformatf("%s.busy", tag), {31'd0, busy}, {31'd0, !want_idle});
   endtask

   // Builds the expected waveform, fires the strobes, then checks every cycle until the job ends.
   // spam: random strobes during the job (must be ignored); abort_at > 0: reset after that entry.
   task automatic applyStimulus(input string name, input logic do_write, input logic do_meta,
                                input logic [31:0] data, input logic [3:0] mask, input logic [7:0] meta,
                                input logic spam, input int abort_at);
      logic [7:0]            bytes_q[$];
      logic [FRAME_BITS-1:0] fr;
      logic [7:0]            b;
      exp_q.delete();
      if (do_write) begin
         for (int k = 0; k < 4; k++) begin
            if (!mask[k]) bytes_q.push_back(data[8*k +: 8]);
         end
      end else if (do_meta) begin
         bytes_q.push_back(meta);
      end
      exp_q.push_back(2'b10);
      foreach (bytes_q[j]) begin
         b = bytes_q[j];
`ifdef UART_TX_PARITY_EN
         fr = {1'b1, ^b, b, 1'b0};
`else
         fr = {1'b1, b, 1'b0};
`endif
         for (int bit_i = 0; bit_i < FRAME_BITS; bit_i++) begin
            for (int r = 0; r < BAUD; r++) exp_q.push_back({fr[bit_i], 1'b0});
         end
         exp_q.push_back(2'b10);
      end
      exp_q.push_back(2'b11);

      @(negedge clock);
      dataIn         = data;
      disabledGroups = mask;
      meta_data      = meta;
      write          = do_write;
      writeMeta      = do_meta;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clock);
         write     = 1'b0;
         writeMeta = 1'b0;
         checkAll($sformatf("%s[c%0d]", name, i + 1), exp_q[i][1], exp_q[i][0]);
         if (abort_at > 0 && i == abort_at) begin
            extReset = 1'b1;
            @(negedge clock);
            extReset = 1'b0;
            checkAll($sformatf("%s.abort", name), 1'b1, 1'b1);
            return;
         end
         if (spam && i < exp_q.size() - 1) begin
            write     = 1'($urandom_range(0, 1));
            writeMeta = 1'($urandom_range(0, 1));
            dataIn    = $urandom;
            meta_data = 8'($urandom);
         end
      end
   endtask

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      extReset       = 1'b1;
      dataIn         = '0;
      disabledGroups = '0;
      write          = 1'b0;
      writeMeta      = 1'b0;
      meta_data      = '0;
      repeat (3) @(negedge clock);
      extReset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         checkAll($sformatf("reset_idle[%0d]", i), 1'b1, 1'b1);
      end

      applyStimulus("meta_a5",   1'b0, 1'b1, 32'h0,        4'b0000, 8'hA5, 1'b0, 0);
      applyStimulus("word_mask", 1'b1, 1'b0, 32'h44332211, 4'b0100, 8'h00, 1'b0, 0);
      applyStimulus("all_off",   1'b1, 1'b0, 32'hDEADBEEF, 4'b1111, 8'h00, 1'b0, 0);
      applyStimulus("both_spam", 1'b1, 1'b1, 32'hC3A55A01, 4'b0000, 8'h77, 1'b1, 0);
      applyStimulus("abort",     1'b0, 1'b1, 32'h0,        4'b0000, 8'hFF, 1'b0, 20);
      applyStimulus("meta_3c",   1'b0, 1'b1, 32'h0,        4'b0000, 8'h3C, 1'b0, 0);

      for (int n = 0; n < 8; n++) begin
         int mode;
         mode = $urandom_range(0, 2);
         applyStimulus($sformatf("rand%0d", n), 1'(mode != 1), 1'(mode != 0),
                       $urandom, 4'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule
